// File: rtl/write_back.sv
// Write-back stage of the 5-stage Beta pipeline: registers the MEM outputs,
// selects register-file write data and stalls upstream while a load is outstanding.
module write_back #(
  parameter int unsigned LD_TIMEOUT = 15,
  parameter logic [31:0] NOP_INST   = 32'h83FFF800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] y,
  input  logic        op_ld_or_ldr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        wb_stall,
  output logic        mem_err
);

  // Handshake: mem_rvalid qualifies mem_rdata in the cycle it is high; while
  // wb_stall is high every upstream register must hold its value.

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    WAIT_LD = 1'b1
  } state_t;

  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [7:0] TMO    = 8'(LD_TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;

  logic [31:0] pc_wb;
  logic [31:0] ir_wb;
  logic [31:0] y_wb;
  logic        ld_wb;

  logic [5:0]  opcode;
  logic [4:0]  rc;
  logic        link;
  logic        store;
  logic        writes;
  logic        tmo_hit;

  // The literal/offset field is never needed at write-back.
  logic        unused_ir_low;
  assign unused_ir_low = ^ir_wb[20:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_wb <= 32'd0;
      ir_wb <= NOP_INST;
      y_wb  <= 32'd0;
      ld_wb <= 1'b0;
    end else if (!wb_stall) begin
      pc_wb <= pc;
      ir_wb <= ir;
      y_wb  <= y;
      ld_wb <= op_ld_or_ldr;
    end
  end

  assign opcode  = ir_wb[31:26];
  assign rc      = ir_wb[25:21];
  assign link    = (opcode == OP_JMP) || (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign store   = (opcode == OP_ST);
  assign writes  = !store && (rc != 5'd31);
  assign tmo_hit = (cnt >= TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (ld_wb && !mem_rvalid) begin
          state_nxt = WAIT_LD;
          cnt_nxt   = 8'd1;
        end
      end
      WAIT_LD: begin
        if (mem_rvalid || tmo_hit) begin
          state_nxt = RUN;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt   = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // An abandoned load releases the stall so the next instruction can enter.
  always_comb begin
    rf_we    = 1'b0;
    wb_stall = 1'b0;
    mem_err  = 1'b0;
    case (state)
      RUN: begin
        if (!ld_wb || mem_rvalid) rf_we = writes;
        else                      wb_stall = 1'b1;
      end
      WAIT_LD: begin
        if (mem_rvalid)   rf_we = writes;
        else if (tmo_hit) mem_err = 1'b1;
        else              wb_stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign rf_wa = rc;

  always_comb begin
    if (link)       rf_wd = pc_wb;
    else if (ld_wb) rf_wd = mem_rdata;
    else            rf_wd = y_wb;
  end

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: the driver pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_write_back;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] y;
  logic        op_ld_or_ldr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        wb_stall;
  logic        mem_err;

  logic [39:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  localparam logic [31:0] NOP = 32'h83FFF800;

  write_back #(.LD_TIMEOUT(15), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .ir(ir), .y(y),
    .op_ld_or_ldr(op_ld_or_ldr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .wb_stall(wb_stall), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rc);
    return {op, rc, 21'd0};
  endfunction

  function automatic logic [39:0] ev(input logic we, input logic [4:0] wa,
                                     input logic [31:0] wd, input logic st, input logic er);
    return {we, wa, wd, st, er};
  endfunction

  // Drives next-entering instruction plus memory response for the current WB cycle.
  task automatic cyc(input logic [31:0] npc, input logic [31:0] nir, input logic [31:0] ny,
                     input logic nld, input logic rv, input logic [31:0] rd,
                     input logic [39:0] e);
    pc = npc; ir = nir; y = ny; op_ld_or_ldr = nld;
    mem_rvalid = rv; mem_rdata = rd;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    logic [39:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {rf_we, rf_wa, rf_wd, wb_stall, mem_err};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL wb_out t=%0t got we=%b wa=%0d wd=%h stall=%b err=%b want we=%b wa=%0d wd=%h stall=%b err=%b",
                 $time, a[39], a[38:34], a[33:2], a[1], a[0], e[39], e[38:34], e[33:2], e[1], e[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] rst_exp;
    logic [31:0] ld9;
    rst_exp = ev(1'b0, 5'd31, 32'd0, 1'b0, 1'b0);
    ld9 = ins(6'h18, 5'd9);
    rst_n = 1'b0; pc = 0; ir = NOP; y = 0; op_ld_or_ldr = 0; mem_rdata = 0; mem_rvalid = 0;
    @(posedge clk); #1;
    cyc(32'd0, NOP, 32'd0, 1'b0, 1'b0, 32'd0, rst_exp);
    cyc(32'd0, NOP, 32'd0, 1'b0, 1'b0, 32'd0, rst_exp);
    rst_n = 1'b1;

    // ADD R3 enters; regs still hold the reset NOP this cycle
    cyc(32'h4, ins(6'h20, 5'd3), 32'h1234, 1'b0, 1'b0, 32'd0, rst_exp);
    cyc(32'h8, ins(6'h18, 5'd5), 32'h100, 1'b1, 1'b0, 32'd0, ev(1, 5'd3, 32'h1234, 0, 0));
    // zero-wait LD R5
    cyc(32'hC, ins(6'h1F, 5'd7), 32'h200, 1'b1, 1'b1, 32'hCAFEF00D, ev(1, 5'd5, 32'hCAFEF00D, 0, 0));
    // LDR R7 with data three cycles late; LD R9 held upstream
    for (int i = 0; i < 3; i++)
      cyc(32'h10, ld9, 32'h300, 1'b1, 1'b0, 32'hDEAD0000, ev(0, 5'd7, 32'hDEAD0000, 1, 0));
    cyc(32'h10, ld9, 32'h300, 1'b1, 1'b1, 32'h55AA55AA, ev(1, 5'd7, 32'h55AA55AA, 0, 0));
    // LD R9 never answered: 15 stall cycles then a single mem_err pulse
    for (int i = 0; i < 15; i++)
      cyc(32'h14, ins(6'h20, 5'd4), 32'h4444, 1'b0, 1'b0, 32'h0BAD0000, ev(0, 5'd9, 32'h0BAD0000, 1, 0));
    cyc(32'h14, ins(6'h20, 5'd4), 32'h4444, 1'b0, 1'b0, 32'h0BAD0000, ev(0, 5'd9, 32'h0BAD0000, 0, 1));
    cyc(32'h104, ins(6'h1C, 5'd2), 32'h9999, 1'b0, 1'b0, 32'd0, ev(1, 5'd4, 32'h4444, 0, 0));
    // BEQ R2 links pc, ST and R31 never write
    cyc(32'h108, ins(6'h19, 5'd6), 32'h66, 1'b0, 1'b0, 32'd0, ev(1, 5'd2, 32'h104, 0, 0));
    cyc(32'h10C, ins(6'h20, 5'd31), 32'h77, 1'b0, 1'b0, 32'd0, ev(0, 5'd6, 32'h66, 0, 0));
    // stray mem_rvalid under a non-load is ignored
    cyc(32'h110, ins(6'h18, 5'd10), 32'h500, 1'b1, 1'b1, 32'h00000BAD, ev(0, 5'd31, 32'h77, 0, 0));
    // LD R10 waits until the counter reaches 6, then reset hits
    for (int i = 0; i < 6; i++)
      cyc(32'h114, ins(6'h20, 5'd11), 32'hB, 1'b0, 1'b0, 32'h1111, ev(0, 5'd10, 32'h1111, 1, 0));
    rst_n = 1'b0;
    cyc(32'h114, ins(6'h20, 5'd11), 32'hB, 1'b0, 1'b0, 32'h1111, rst_exp);
    cyc(32'h114, ins(6'h20, 5'd11), 32'hB, 1'b0, 1'b0, 32'h1111, rst_exp);
    rst_n = 1'b1;
    cyc(32'h118, ins(6'h20, 5'd11), 32'hB, 1'b0, 1'b0, 32'h1111, rst_exp);
    cyc(32'h11C, ins(6'h20, 5'd12), 32'hC, 1'b0, 1'b0, 32'h1111, ev(1, 5'd11, 32'hB, 0, 0));
    cyc(32'h120, NOP, 32'd0, 1'b0, 1'b0, 32'd0, ev(1, 5'd12, 32'hC, 0, 0));

    @(negedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
